vram_sdram_bridge: RTL

//  Downstream of the V99 VDP device's vram_bus: converts its per-cycle VRAM strobes into

---
 rtl/vram_bridge_pkg.sv | 27 ++
 rtl/vram_wr_fifo.sv | 56 +++++
 rtl/vram_sdram_bridge.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vram_bridge_pkg.sv
// Shared types for the VRAM-to-SDRAM bridge: posted-write entry, FSM states and
// the byte-lane forwarding helper.
package vram_bridge_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  be;
    logic [7:0]  data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_e;

  // Newest-wins overlay of one byte lane; callers apply entries oldest first.
  function automatic logic [7:0] merge_lane(input logic [7:0]  cur,
                                            input wr_entry_t   ent,
                                            input logic        vld,
                                            input logic [15:0] rd_addr,
                                            input logic        lane);
    if (vld && (ent.addr == rd_addr) && ent.be[lane]) return ent.data;
    return cur;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Register FIFO for posted VRAM writes; every entry is visible, oldest first,
// so pending data can be forwarded into read results.
module vram_wr_fifo
  import vram_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  wr_entry_t             din_i,
  output wr_entry_t             ent_o [FIFO_DEPTH],
  output logic [FIFO_DEPTH-1:0] vld_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  wr_entry_t     mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_comb begin
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      ent_o[i] = mem_q[rd_ptr_q + PW'(i)];
      vld_o[i] = ((PW+1)'(i) < count_q);
    end
  end

endmodule

// File: rtl/vram_sdram_bridge.sv
// Turns VDP per-cycle VRAM strobes into req/ack transactions on a shared memory
// port: reads on address change, writes posted through a FIFO with forwarding.
module vram_sdram_bridge
  import vram_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        we_lo,
  input  logic        we_hi,
  output logic [7:0]  q_lo,
  output logic [7:0]  q_hi,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        overflow
);

  logic                  we_lo_q, we_hi_q;
  logic [1:0]            rise_be;
  logic                  push, pop, push_acc;
  wr_entry_t             push_ent;
  wr_entry_t             fifo_ent [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic                  fifo_full, fifo_empty;
  state_e                state_q, state_d;
  logic                  rd_pend_q, rd_pend_d, rd_valid_q, rd_valid_d;
  logic [15:0]           last_rd_addr_q, last_rd_addr_d;
  logic [7:0]            q_lo_q, q_lo_d, q_hi_q, q_hi_d, fwd_lo, fwd_hi;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [15:0]           mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]            mem_be_q, mem_be_d;
  logic                  overflow_q, overflow_d;
  logic                  addr_chg, need_rd;

  assign rise_be    = {we_hi & ~we_hi_q, we_lo & ~we_lo_q};
  assign push       = |rise_be;
  assign push_ent   = '{addr: addr, be: rise_be, data: data};
  assign addr_chg   = (addr != last_rd_addr_q);
  assign need_rd    = rd_pend_q | addr_chg | ~rd_valid_q;
  assign pop        = (state_q == IDLE) && !need_rd && !fifo_empty;
  assign push_acc   = push && (!fifo_full || pop);
  assign overflow_d = overflow_q | (push & ~push_acc);

  vram_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_ent),
    .ent_o   (fifo_ent),
    .vld_o   (fifo_vld),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reads never overlap a write, so only queued entries and a same-cycle push
  // can be newer than the memory data.
  always_comb begin
    fwd_lo = mem_rdata[7:0];
    fwd_hi = mem_rdata[15:8];
    if (FWD_EN) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fwd_lo = merge_lane(fwd_lo, fifo_ent[i], fifo_vld[i], last_rd_addr_q, 1'b0);
        fwd_hi = merge_lane(fwd_hi, fifo_ent[i], fifo_vld[i], last_rd_addr_q, 1'b1);
      end
      fwd_lo = merge_lane(fwd_lo, push_ent, push_acc, last_rd_addr_q, 1'b0);
      fwd_hi = merge_lane(fwd_hi, push_ent, push_acc, last_rd_addr_q, 1'b1);
    end
  end

  always_comb begin
    state_d        = state_q;
    rd_pend_d      = rd_pend_q | addr_chg;
    rd_valid_d     = rd_valid_q;
    last_rd_addr_d = last_rd_addr_q;
    q_lo_d         = q_lo_q;
    q_hi_d         = q_hi_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_be_d       = mem_be_q;
    mem_wdata_d    = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (need_rd) begin
          mem_req_d      = 1'b1;
          mem_we_d       = 1'b0;
          mem_be_d       = 2'b11;
          mem_addr_d     = addr;
          last_rd_addr_d = addr;
          rd_pend_d      = 1'b0;
          state_d        = RD_WAIT;
        end else if (!fifo_empty) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_be_d    = fifo_ent[0].be;
          mem_addr_d  = fifo_ent[0].addr;
          mem_wdata_d = {fifo_ent[0].data, fifo_ent[0].data};
          state_d     = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          q_lo_d     = fwd_lo;
          q_hi_d     = fwd_hi;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      we_lo_q        <= 1'b0;
      we_hi_q        <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
      last_rd_addr_q <= '1;
      q_lo_q         <= '0;
      q_hi_q         <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_be_q       <= '0;
      mem_wdata_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_lo_q        <= we_lo;
      we_hi_q        <= we_hi;
      rd_pend_q      <= rd_pend_d;
      rd_valid_q     <= rd_valid_d;
      last_rd_addr_q <= last_rd_addr_d;
      q_lo_q         <= q_lo_d;
      q_hi_q         <= q_hi_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_be_q       <= mem_be_d;
      mem_wdata_q    <= mem_wdata_d;
      overflow_q     <= overflow_d;
    end
  end

  assign q_lo      = q_lo_q;
  assign q_hi      = q_hi_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign overflow  = overflow_q;

endmodule
